// File: rtl/saf_pkg.sv
// Shared definitions for the spline adaptive filter update blocks:
// sweep FSM states, rounding constant and saturation helper.
package saf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } upd_state_t;

    // Half an output LSB for round-half-up after a right shift by qp.
    function automatic logic signed [63:0] round_half(input int qp);
        return 64'sd1 <<< (qp - 1);
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_s(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/wu_round_mul.sv
// Registered signed multiply with round-half-up and Q-format slice.
// W_UPD_SAT_EN: clamp the sliced term instead of wrapping.
module wu_round_mul
    import saf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAGW  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [TAGW-1:0]         in_tag,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] term,
    output logic [TAGW-1:0]         out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] HALF = PW'(round_half(QP));

    logic signed [PW-1:0]    a_x;
    logic signed [PW-1:0]    b_x;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] term_d;

    assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod = a_x * b_x + HALF;

    // Slice the rounded product down to one word (clamped or wrapped).
    always_comb begin
        term_d = '0;
`ifdef W_UPD_SAT_EN
        term_d = WIDTH'(sat_s(64'(prod >>> QP), WIDTH));
`else
        term_d = WIDTH'(prod >>> QP);
`endif
    end

    // Stage register: term, valid and the tap index travel together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            term      <= '0;
            out_tag   <= '0;
        end else begin
            out_valid <= in_valid;
            term      <= term_d;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/w_update_bank_seq.sv
// Time-multiplexed LMS weight update: w[k] += round(x[k]*mu_error).
// W_UPD_SAT_EN: saturating term and weight add (default wraps).
module w_update_bank_seq
    import saf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               QP        = 12,
    parameter int               NTAPS     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic signed [WIDTH-1:0]  x_in,
    input  logic                     upd_start,
    input  logic signed [WIDTH-1:0]  mu_error,
    output logic                     busy,
    output logic                     upd_done,
    output logic [NTAPS*WIDTH-1:0]   x_taps_flat,
    output logic [NTAPS*WIDTH-1:0]   weights_flat
);

    localparam int IW = $clog2(NTAPS);
    localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

    logic signed [WIDTH-1:0] taps    [NTAPS];
    logic signed [WIDTH-1:0] weights [NTAPS];

    upd_state_t              state;
    logic [IW-1:0]           idx;
    logic signed [WIDTH-1:0] mu_q;

    logic                    x_acc;
    logic                    issue;
    logic signed [WIDTH-1:0] tap_sel;

    logic                    wv;
    logic signed [WIDTH-1:0] wterm;
    logic [IW-1:0]           widx;
    logic signed [WIDTH-1:0] wsum;

    assign x_ready = ~busy;
    assign x_acc   = x_valid & x_ready;
    assign issue   = (state == RUN);
    assign tap_sel = taps[idx];

    // Input delay line, frozen while a sweep reads it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (x_acc) begin
            taps[0] <= x_in;
            for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // Sweep sequencer: IDLE -> RUN (one tap per cycle) -> DRAIN -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            mu_q     <= '0;
            busy     <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (upd_start) begin
                        mu_q  <= mu_error;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    busy     <= 1'b0;
                    upd_done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    wu_round_mul #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .TAGW  (IW)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .a         (tap_sel),
        .b         (mu_q),
        .in_tag    (idx),
        .out_valid (wv),
        .term      (wterm),
        .out_tag   (widx)
    );

    // Accumulate the term into the addressed weight.
    always_comb begin
        wsum = '0;
`ifdef W_UPD_SAT_EN
        wsum = WIDTH'(sat_s(64'(weights[widx]) + 64'(wterm), WIDTH));
`else
        wsum = weights[widx] + wterm;
`endif
    end

    // Weight bank write port; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) weights[k] <= RESET_VAL;
        end else if (wv) begin
            weights[widx] <= wsum;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_flat
        assign x_taps_flat[g*WIDTH +: WIDTH]  = taps[g];
        assign weights_flat[g*WIDTH +: WIDTH] = weights[g];
    end

endmodule

// File: tb/tb_w_update_bank_seq.sv
// Scoreboard bench for w_update_bank_seq: expected weight banks are
// queued per sweep and compared when upd_done pulses.
module tb_w_update_bank_seq;

    localparam int W  = 16;
    localparam int QP = 12;
    localparam int N  = 8;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          x_valid;
    logic          x_ready;
    logic [W-1:0]  x_in;
    logic          upd_start;
    logic [W-1:0]  mu_error;
    logic          busy;
    logic          upd_done;
    logic [FW-1:0] x_taps_flat;
    logic [FW-1:0] weights_flat;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [W-1:0] m_taps [N];
    logic signed [W-1:0] m_w    [N];
    logic [FW-1:0]       sb_q   [$];

    always #5 clk = ~clk;

    w_update_bank_seq #(
        .WIDTH     (W),
        .QP        (QP),
        .NTAPS     (N),
        .RESET_VAL ('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_in         (x_in),
        .upd_start    (upd_start),
        .mu_error     (mu_error),
        .busy         (busy),
        .upd_done     (upd_done),
        .x_taps_flat  (x_taps_flat),
        .weights_flat (weights_flat)
    );

    task automatic chk(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [W-1:0] m_term(
        input logic signed [W-1:0] t, input logic signed [W-1:0] m);
        longint p;
        longint s;
        p = longint'(t) * longint'(m) + (64'sd1 <<< (QP - 1));
        s = p >>> QP;
`ifdef W_UPD_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return W'(s);
    endfunction

    function automatic logic signed [W-1:0] m_add(
        input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
`ifdef W_UPD_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return W'(s);
    endfunction

    function automatic logic [FW-1:0] pack_w();
        logic [FW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_w[k];
        return v;
    endfunction

    function automatic logic [FW-1:0] pack_t();
        logic [FW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_taps[k];
        return v;
    endfunction

    task automatic m_shift(input logic [W-1:0] x);
        for (int k = N - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = x;
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_taps[k] = '0;
            m_w[k]    = '0;
        end
    endtask

    // Pop one expected bank per upd_done; an unexpected pulse fails.
    always @(posedge clk) begin
        #1;
        if (upd_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                chk("weights", weights_flat, sb_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_reset();
    endtask

    task automatic shift(input logic [W-1:0] x);
        x_valid = 1'b1;
        x_in    = x;
        tick();
        x_valid = 1'b0;
        m_shift(x);
        chk("taps_shift", x_taps_flat, pack_t());
    endtask

    // Start a sweep; optionally shift on the same edge, poke upd_start
    // during busy, or hold x_valid through busy. Ends in cycle T+10
    // (or T+11 when hold_x) without advancing further.
    task automatic sweep(input logic [W-1:0] mu, input bit with_x,
                         input logic [W-1:0] x, input bit poke,
                         input bit hold_x, input logic [W-1:0] hx);
        bit ok;
        upd_start = 1'b1;
        mu_error  = mu;
        if (with_x) begin
            x_valid = 1'b1;
            x_in    = x;
            m_shift(x);
        end
        for (int k = 0; k < N; k++) m_w[k] = m_add(m_w[k], m_term(m_taps[k], mu));
        sb_q.push_back(pack_w());
        tick();
        upd_start = 1'b0;
        x_valid   = 1'b0;
        ok = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            if (busy !== 1'b1 || upd_done !== 1'b0 || x_ready !== 1'b0) ok = 1'b0;
            mu_error  = W'($urandom);
            upd_start = poke;
            if (hold_x) begin
                x_valid = 1'b1;
                x_in    = hx;
            end
            tick();
        end
        upd_start = 1'b0;
        chk("busy_window", FW'(ok), 1);
        chk("done_pulse", FW'({upd_done, busy, x_ready}), FW'(3'b101));
        if (hold_x) begin
            m_shift(hx);
            tick();
            x_valid = 1'b0;
        end
        chk("taps_after", x_taps_flat, pack_t());
    endtask

    initial begin
        reset     = 1'b0;
        x_valid   = 1'b0;
        x_in      = '0;
        upd_start = 1'b0;
        mu_error  = '0;
        m_reset();

        // Reset state
        tick();
        tick();
        chk("rst_weights", weights_flat, 0);
        chk("rst_taps", x_taps_flat, 0);
        chk("rst_busy", FW'(busy), 0);
        chk("rst_ready", FW'(x_ready), 1);
        chk("rst_done", FW'(upd_done), 0);
        reset = 1'b1;
        tick();

        // Basic sweep: expect w0=512, w1=1024
        shift(16'd4096);
        shift(16'd2048);
        sweep(16'd1024, 0, 0, 0, 0, 0);
        chk("basic_w01", FW'(weights_flat[2*W-1:0]), FW'({16'd1024, 16'd512}));

        // Rounding boundaries
        do_reset();
        shift(16'd1);
        sweep(16'd2048, 0, 0, 0, 0, 0);
        chk("rnd_half_up", FW'(weights_flat[W-1:0]), 1);
        sweep(16'd2047, 0, 0, 0, 0, 0);
        chk("rnd_below", FW'(weights_flat[W-1:0]), 1);
        shift(16'hFFFF);
        sweep(16'd2048, 0, 0, 0, 0, 0);
        chk("rnd_neg_half", FW'(weights_flat[W-1:0]), 1);

        // Overflow at the weight add
        do_reset();
        shift(16'd4096);
        sweep(16'd32000, 0, 0, 0, 0, 0);
        sweep(16'd1024, 0, 0, 0, 0, 0);
`ifdef W_UPD_SAT_EN
        chk("ovf_w0", FW'(weights_flat[W-1:0]), FW'(16'd32767));
`else
        chk("ovf_w0", FW'(weights_flat[W-1:0]), FW'(16'h8100));
`endif

        // Handshake: pokes during busy, held x_valid, same-edge shift
        do_reset();
        shift(16'd300);
        shift(16'hF000);
        sweep(16'd700, 0, 0, 1, 0, 0);
        sweep(16'hFE00, 0, 0, 0, 1, 16'd1234);
        sweep(16'd3000, 1, 16'd5555, 0, 0, 0);
        sweep(16'h9000, 1, 16'h8001, 1, 0, 0);

        // Random back-to-back sweeps
        for (int i = 0; i < 4; i++) begin
            shift(W'($urandom));
            sweep(W'($urandom), 1, W'($urandom), 0, 0, 0);
            sweep(W'($urandom), 0, 0, 1, 0, 0);
        end

        // Abort mid-sweep with reset sampled at edge T+4
        upd_start = 1'b1;
        mu_error  = 16'd4000;
        tick();
        upd_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_reset();
        chk("abort_busy", FW'(busy), 0);
        chk("abort_weights", weights_flat, 0);
        chk("abort_taps", x_taps_flat, 0);
        for (int c = 0; c < 15; c++) tick();
        chk("sb_empty", FW'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
